// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; 1-cycle grant latency, then zero-latency paths.
// Backpressure: non-owner held stalled; owner sees the slave's stall; watchdog ends hung cycles.
module wb_arbiter_2m #(
  parameter int WB_BUS_WIDTH  = 16,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int TIMEOUT       = 255,
  parameter int TO_WIDTH      = 8,
  localparam int WB_SEL       = WB_BUS_WIDTH / 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_reset_n_i,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic                     m0_lock_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_BUS_WIDTH-1:0]  m0_data_i,
  input  logic [WB_SEL-1:0]        m0_sel_i,
  output logic [WB_BUS_WIDTH-1:0]  m0_data_o,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  output logic                     m0_rty_o,
  output logic                     m0_stall_o,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic                     m1_lock_i,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_BUS_WIDTH-1:0]  m1_data_i,
  input  logic [WB_SEL-1:0]        m1_sel_i,
  output logic [WB_BUS_WIDTH-1:0]  m1_data_o,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic                     m1_rty_o,
  output logic                     m1_stall_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic                     s_lock_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_BUS_WIDTH-1:0]  s_data_o,
  output logic [WB_SEL-1:0]        s_sel_o,
  input  logic [WB_BUS_WIDTH-1:0]  s_data_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  input  logic                     s_rty_i,
  input  logic                     s_stall_i,
  output logic                     timeout_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit                WDOG_EN = (TIMEOUT > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic                last, last_nxt;
  logic [TO_WIDTH-1:0] wdog, wdog_nxt;

  logic                     busy, term, fire;
  logic                     own_cyc, own_stb, own_we, own_lock;
  logic [WB_ADDR_WIDTH-1:0] own_addr;
  logic [WB_BUS_WIDTH-1:0]  own_data;
  logic [WB_SEL-1:0]        own_sel;

  assign own_cyc  = owner ? m1_cyc_i  : m0_cyc_i;
  assign own_stb  = owner ? m1_stb_i  : m0_stb_i;
  assign own_we   = owner ? m1_we_i   : m0_we_i;
  assign own_lock = owner ? m1_lock_i : m0_lock_i;
  assign own_addr = owner ? m1_addr_i : m0_addr_i;
  assign own_data = owner ? m1_data_i : m0_data_i;
  assign own_sel  = owner ? m1_sel_i  : m0_sel_i;

  assign busy = (state == BUSY);
  assign term = s_ack_i | s_err_i | s_rty_i;
  // A real slave termination in the firing cycle always beats the watchdog.
  assign fire = WDOG_EN && busy && own_cyc && !term && (wdog == TO_LAST);

  assign s_cyc_o   = busy & own_cyc & ~fire;
  assign s_stb_o   = busy & own_stb & ~fire;
  assign s_we_o    = busy & own_we;
  assign s_lock_o  = busy & own_lock;
  assign s_addr_o  = busy ? own_addr : '0;
  assign s_data_o  = busy ? own_data : '0;
  assign s_sel_o   = busy ? own_sel  : '0;
  assign timeout_o = fire;

  assign m0_data_o  = s_data_i;
  assign m1_data_o  = s_data_i;
  assign m0_ack_o   = busy & ~owner & s_ack_i;
  assign m1_ack_o   = busy &  owner & s_ack_i;
  assign m0_err_o   = busy & ~owner & (s_err_i | fire);
  assign m1_err_o   = busy &  owner & (s_err_i | fire);
  assign m0_rty_o   = busy & ~owner & s_rty_i;
  assign m1_rty_o   = busy &  owner & s_rty_i;
  assign m0_stall_o = ~(busy & ~owner) | s_stall_i;
  assign m1_stall_o = ~(busy &  owner) | s_stall_i;

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    wdog_nxt  = '0;
    case (state)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_nxt = BUSY;
          owner_nxt = (m0_cyc_i && m1_cyc_i) ? ~last : m1_cyc_i;
        end
      end
      BUSY: begin
        if (fire || (!own_cyc && !own_lock)) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else if (own_cyc && !term) begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: per-cycle vector table plus reset sequences.
module tb_wb_arbiter_2m;

  localparam int BW = 16;
  localparam int AW = 32;
  localparam int SW = BW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [BW-1:0] m0_wdat, m0_rdat;
  logic [SW-1:0] m0_sel;
  logic          m0_ack, m0_err, m0_rty, m0_stall;
  logic          m1_cyc, m1_stb, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [BW-1:0] m1_wdat, m1_rdat;
  logic [SW-1:0] m1_sel;
  logic          m1_ack, m1_err, m1_rty, m1_stall;
  logic          s_cyc, s_stb, s_we, s_lock;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_wdat, s_rdat;
  logic [SW-1:0] s_sel;
  logic          s_ack, s_err, s_rty, s_stall;
  logic          tmo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.WB_BUS_WIDTH(BW), .WB_ADDR_WIDTH(AW), .TIMEOUT(4), .TO_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_reset_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_sel_i(m0_sel), .m0_data_o(m0_rdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty), .m0_stall_o(m0_stall),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_sel_i(m1_sel), .m1_data_o(m1_rdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty), .m1_stall_o(m1_stall),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_lock_o(s_lock),
    .s_addr_o(s_addr), .s_data_o(s_wdat), .s_sel_o(s_sel), .s_data_i(s_rdat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_stall_i(s_stall),
    .timeout_o(tmo)
  );

  // in  = {m0_cyc, m0_stb, m0_lock, m1_cyc, m1_stb, s_ack}
  // exp = {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err, timeout}
  typedef struct packed {
    logic [5:0]    in;
    logic [8:0]    exp;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t vt[35];

  function automatic vec_t mk(input logic [5:0] i, input logic [8:0] e, input logic [AW-1:0] a);
    vec_t v;
    v.in = i; v.exp = e; v.addr = a;
    return v;
  endfunction

  function automatic logic [8:0] obs();
    return {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err, tmo};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] IDL = 9'b00_11_0000_0;

  initial begin
    logic [BW-1:0] edat;
    logic [63:0]   rst_exp;

    vt[0]  = mk(6'b000110, IDL,          32'h0);
    vt[1]  = mk(6'b000110, 9'b11_10_0000_0, 32'hA0);
    vt[2]  = mk(6'b000101, 9'b10_10_0100_0, 32'hA0);
    vt[3]  = mk(6'b000000, 9'b00_10_0000_0, 32'hA0);
    vt[4]  = mk(6'b110110, IDL,          32'h0);
    vt[5]  = mk(6'b110111, 9'b11_01_1000_0, 32'h10);
    vt[6]  = mk(6'b000110, 9'b00_01_0000_0, 32'h10);
    vt[7]  = mk(6'b110110, IDL,          32'h0);
    vt[8]  = mk(6'b110111, 9'b11_10_0100_0, 32'hA0);
    vt[9]  = mk(6'b110000, 9'b00_10_0000_0, 32'hA0);
    vt[10] = mk(6'b110110, IDL,          32'h0);
    vt[11] = mk(6'b110111, 9'b11_01_1000_0, 32'h10);
    vt[12] = mk(6'b000110, 9'b00_01_0000_0, 32'h10);
    vt[13] = mk(6'b111000, IDL,          32'h0);
    vt[14] = mk(6'b111111, 9'b11_01_1000_0, 32'h10);
    vt[15] = mk(6'b001110, 9'b00_01_0000_0, 32'h10);
    vt[16] = mk(6'b001110, 9'b00_01_0000_0, 32'h10);
    vt[17] = mk(6'b001110, 9'b00_01_0000_0, 32'h10);
    vt[18] = mk(6'b000110, 9'b00_01_0000_0, 32'h10);
    vt[19] = mk(6'b000110, IDL,          32'h0);
    vt[20] = mk(6'b000111, 9'b11_10_0100_0, 32'hA0);
    vt[21] = mk(6'b000000, 9'b00_10_0000_0, 32'hA0);
    vt[22] = mk(6'b110000, IDL,          32'h0);
    vt[23] = mk(6'b110000, 9'b11_01_0000_0, 32'h10);
    vt[24] = mk(6'b110000, 9'b11_01_0000_0, 32'h10);
    vt[25] = mk(6'b110000, 9'b11_01_0000_0, 32'h10);
    vt[26] = mk(6'b110000, 9'b00_01_0010_1, 32'h10);
    vt[27] = mk(6'b110000, IDL,          32'h0);
    vt[28] = mk(6'b110000, 9'b11_01_0000_0, 32'h10);
    vt[29] = mk(6'b110000, 9'b11_01_0000_0, 32'h10);
    vt[30] = mk(6'b110000, 9'b11_01_0000_0, 32'h10);
    vt[31] = mk(6'b110001, 9'b11_01_1000_0, 32'h10);
    vt[32] = mk(6'b110000, 9'b11_01_0000_0, 32'h10);
    vt[33] = mk(6'b000000, 9'b00_01_0000_0, 32'h10);
    vt[34] = mk(6'b000000, IDL,          32'h0);

    rst_n = 1'b0;
    {m0_cyc, m0_stb, m0_lock, m1_cyc, m1_stb, m1_lock} = '0;
    m0_we = 1'b0; m0_addr = 32'h10; m0_wdat = 16'h1111; m0_sel = 2'b01;
    m1_we = 1'b1; m1_addr = 32'hA0; m1_wdat = 16'hBEEF; m1_sel = 2'b11;
    s_rdat = 16'h5A5A; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_stall = 1'b0;

    #12;
    rst_exp = {18'd0, IDL, 3'b000, 32'h0, 2'b00};
    check("reset_state", {18'd0, obs(), s_we, s_lock, m0_rty | m1_rty, s_addr, s_sel},
          rst_exp);
    check("rdata_bcast", {32'd0, m0_rdat, m1_rdat}, {32'd0, 16'h5A5A, 16'h5A5A});
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 35; i++) begin
      {m0_cyc, m0_stb, m0_lock, m1_cyc, m1_stb, s_ack} = vt[i].in;
      #1;
      edat = (vt[i].addr == 32'hA0) ? 16'hBEEF : (vt[i].addr == 32'h10) ? 16'h1111 : 16'h0;
      check($sformatf("vec%0d", i), {7'd0, obs(), s_addr, s_wdat},
            {7'd0, vt[i].exp, vt[i].addr, edat});
      tick();
    end

    // Reset while m1 owns the bus, with the slave acking.
    {m0_cyc, m0_stb, m0_lock, m1_cyc, m1_stb, s_ack} = 6'b000110;
    tick();
    #1;
    check("m1_granted", {55'd0, obs()}, {55'd0, 9'b11_10_0000_0});
    s_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_midbusy", {55'd0, obs()}, {55'd0, IDL});
    #3;
    rst_n = 1'b1;
    s_ack = 1'b0;
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = 4'b1111;
    #1;
    check("post_reset_idle", {55'd0, obs()}, {55'd0, IDL});
    tick();
    check("post_reset_m0_wins", {23'd0, m0_stall, m1_stall, s_cyc, s_addr, 7'd0},
          {23'd0, 1'b0, 1'b1, 1'b1, 32'h10, 7'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
